// File: rtl/fetch_pkg.sv
// Shared decode constants, counter encodings and helpers for the fetch stage.
// Optional return stack in fetch_predict is enabled by FETCH_RAS_EN.
package fetch_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bht_ctr_e;

  typedef struct packed {
    logic is_jump;
    logic is_jal;
    logic is_br;
    logic is_jr;
  } slot_dec_t;

  function automatic slot_dec_t decode(
    input logic [31:0] ins
  );
    slot_dec_t d;
    d = '0;
    unique case (ins[31:26])
      OP_J:   d.is_jump = 1'b1;
      OP_JAL: begin
        d.is_jump = 1'b1;
        d.is_jal  = 1'b1;
      end
      OP_BEQ, OP_BNE: d.is_br = 1'b1;
      OP_RTYPE: d.is_jr = (ins[5:0] == FUNCT_JR);
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [1:0] sat_step(
    input logic [1:0] c,
    input logic       up
  );
    logic [1:0] r;
    r = c;
    if (up) begin
      if (c != ST) r = c + 2'd1;
    end else begin
      if (c != SNT) r = c - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_predict_bht.sv
// Direct-mapped bimodal table of 2-bit saturating counters.
// Two combinational lookups see the value before any same-edge update.
module bht_bimodal
  import fetch_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int INIT    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx_1,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx_2,
  output logic                       rd_taken_1,
  output logic                       rd_taken_2,
  input  logic                       upd_en,
  input  logic [$clog2(ENTRIES)-1:0] upd_idx,
  input  logic                       upd_taken
);

  logic [1:0] ctr [ENTRIES];

  assign rd_taken_1 = ctr[rd_idx_1][1];
  assign rd_taken_2 = ctr[rd_idx_2][1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= 2'(INIT);
      end
    end else if (upd_en) begin
      ctr[upd_idx] <= sat_step(ctr[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/fetch_predict.sv
// Dual-slot fetch stage with bimodal branch prediction.
// Define FETCH_RAS_EN to add a circular return address stack.
module fetch_predict
  import fetch_pkg::*;
#(
  parameter int AW          = 10,
  parameter int BHT_ENTRIES = 64,
  parameter int BHT_INIT    = 2,
  parameter int RAS_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          correct_en,
  input  logic [AW-1:0] correction,
  input  logic          jr,
  input  logic [AW-1:0] reg1Addr,
  input  logic          upd_en,
  input  logic [AW-1:0] upd_pc,
  input  logic          upd_taken,
  output logic [AW-1:0] imem_addr_1,
  output logic [AW-1:0] imem_addr_2,
  input  logic [31:0]   imem_data_1,
  input  logic [31:0]   imem_data_2,
  output logic [31:0]   instruction_1,
  output logic [31:0]   instruction_2,
  output logic [AW-1:0] pc_1,
  output logic [AW-1:0] pc_2,
  output logic          valid_1,
  output logic          valid_2,
  output logic          pred_taken_1,
  output logic          pred_taken_2,
  output logic [AW-1:0] pred_target_1,
  output logic [AW-1:0] pred_target_2,
  output logic [AW-1:0] return_addr1,
  output logic [AW-1:0] return_addr2,
  output logic [AW-1:0] nextPC_out
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  logic [AW-1:0] pc;
  logic [AW-1:0] pc_p1;
  logic [AW-1:0] pc_p2;
  logic [AW-1:0] pc_plus;
  logic [AW-1:0] pc_nxt;
  logic [AW-1:0] imm_1;
  logic [AW-1:0] imm_2;
  logic [AW-1:0] ras_top;
  logic          ras_ok;
  logic          bht_t1;
  logic          bht_t2;
  logic          raw_1;
  logic          raw_2;
  logic          advance;
  slot_dec_t     d1;
  slot_dec_t     d2;

  assign pc_p1 = pc + AW'(1);
  assign pc_p2 = pc + AW'(2);
  assign imm_1 = imem_data_1[AW-1:0];
  assign imm_2 = imem_data_2[AW-1:0];
  assign d1    = decode(imem_data_1);
  assign d2    = decode(imem_data_2);

  bht_bimodal #(
    .ENTRIES (BHT_ENTRIES),
    .INIT    (BHT_INIT)
  ) u_bht (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_1   (pc[IDX-1:0]),
    .rd_idx_2   (pc_p1[IDX-1:0]),
    .rd_taken_1 (bht_t1),
    .rd_taken_2 (bht_t2),
    .upd_en     (upd_en),
    .upd_idx    (upd_pc[IDX-1:0]),
    .upd_taken  (upd_taken)
  );

  assign raw_1 = d1.is_jump
               | (d1.is_br & bht_t1)
               | (d1.is_jr & ras_ok);
  assign raw_2 = d2.is_jump
               | (d2.is_br & bht_t2)
               | (d2.is_jr & ras_ok);

  assign valid_1      = rst & ~correct_en & ~jr;
  assign pred_taken_1 = valid_1 & raw_1;
  assign valid_2      = valid_1 & ~pc[0]
                      & ~pred_taken_1;
  assign pred_taken_2 = valid_2 & raw_2;

  always_comb begin
    pred_target_1 = pc_p1 + imm_1;
    if (d1.is_jump)    pred_target_1 = imm_1;
    else if (d1.is_jr) pred_target_1 = ras_top;
    pred_target_2 = pc_p2 + imm_2;
    if (d2.is_jump)    pred_target_2 = imm_2;
    else if (d2.is_jr) pred_target_2 = ras_top;
  end

  assign pc_plus = pc[0] ? pc_p1 : pc_p2;

  always_comb begin
    pc_nxt = pc_plus;
    if (!rst)              pc_nxt = '0;
    else if (correct_en)   pc_nxt = correction;
    else if (jr)           pc_nxt = reg1Addr;
    else if (pred_taken_1) pc_nxt = pred_target_1;
    else if (pred_taken_2) pc_nxt = pred_target_2;
  end

  // correct_en must redirect even while decode holds the stage
  assign advance = ~hold | correct_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         pc <= '0;
    else if (advance) pc <= pc_nxt;
  end

`ifdef FETCH_RAS_EN
  localparam int RW = (RAS_DEPTH > 1) ?
                      $clog2(RAS_DEPTH) : 1;
  localparam logic [RW-1:0] TP_LAST =
                      RW'(RAS_DEPTH - 1);

  logic [AW-1:0] ras [RAS_DEPTH];
  logic [RW-1:0] tp;
  logic [RW-1:0] tp_inc;
  logic [RW-1:0] tp_dec;
  logic [RW:0]   cnt;
  logic          push;
  logic          pop;
  logic [AW-1:0] push_addr;

  assign tp_inc  = (tp == TP_LAST) ? '0 : tp + 1'b1;
  assign tp_dec  = (tp == '0) ? TP_LAST : tp - 1'b1;
  assign ras_top = ras[tp_dec];
  assign ras_ok  = (cnt != '0);

  assign push = advance & ((valid_1 & d1.is_jal)
                         | (valid_2 & d2.is_jal));
  assign pop  = advance & ((pred_taken_1 & d1.is_jr)
                         | (pred_taken_2 & d2.is_jr));
  assign push_addr = (valid_1 & d1.is_jal) ?
                     pc_p1 : pc_p2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tp  <= '0;
      cnt <= '0;
    end else if (push) begin
      tp <= tp_inc;
      if (cnt != (RW+1)'(RAS_DEPTH))
        cnt <= cnt + 1'b1;
    end else if (pop) begin
      tp  <= tp_dec;
      cnt <= cnt - 1'b1;
    end
  end

  // full stack overwrites the oldest slot
  always_ff @(posedge clk) begin
    if (push) ras[tp] <= push_addr;
  end
`else
  logic unused_ras;
  assign ras_ok     = 1'b0;
  assign ras_top    = '0;
  assign unused_ras = ^{d1.is_jal, d2.is_jal};
`endif

  logic unused_bits;
  assign unused_bits = ^{imem_data_1, imem_data_2, upd_pc};

  assign imem_addr_1   = pc;
  assign imem_addr_2   = pc_p1;
  assign instruction_1 = imem_data_1;
  assign instruction_2 = imem_data_2;
  assign pc_1          = pc;
  assign pc_2          = pc_p1;
  assign return_addr1  = pc_p1;
  assign return_addr2  = pc_p2;
  assign nextPC_out    = pc_nxt;

endmodule

// File: tb/tb_fetch_predict.sv
// Bench for fetch_predict: vector table, corner sequences, random model.
// Return stack sequence runs when FETCH_RAS_EN is defined.
module tb_fetch_predict;

  localparam int AW = 10;
  localparam int NPC = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hold = 1'b0;
  logic          correct_en = 1'b0;
  logic [AW-1:0] correction = '0;
  logic          jr = 1'b0;
  logic [AW-1:0] reg1Addr = '0;
  logic          upd_en = 1'b0;
  logic [AW-1:0] upd_pc = '0;
  logic          upd_taken = 1'b0;
  logic [AW-1:0] imem_addr_1, imem_addr_2;
  logic [31:0]   imem_data_1, imem_data_2;
  logic [31:0]   instruction_1, instruction_2;
  logic [AW-1:0] pc_1, pc_2;
  logic          valid_1, valid_2;
  logic          pred_taken_1, pred_taken_2;
  logic [AW-1:0] pred_target_1, pred_target_2;
  logic [AW-1:0] return_addr1, return_addr2;
  logic [AW-1:0] nextPC_out;

  logic [31:0] mem [NPC];
  assign imem_data_1 = mem[imem_addr_1];
  assign imem_data_2 = mem[imem_addr_2];

  always #5 clk = ~clk;

  fetch_predict dut (
    .clk           (clk),
    .rst           (rst),
    .hold          (hold),
    .correct_en    (correct_en),
    .correction    (correction),
    .jr            (jr),
    .reg1Addr      (reg1Addr),
    .upd_en        (upd_en),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .imem_addr_1   (imem_addr_1),
    .imem_addr_2   (imem_addr_2),
    .imem_data_1   (imem_data_1),
    .imem_data_2   (imem_data_2),
    .instruction_1 (instruction_1),
    .instruction_2 (instruction_2),
    .pc_1          (pc_1),
    .pc_2          (pc_2),
    .valid_1       (valid_1),
    .valid_2       (valid_2),
    .pred_taken_1  (pred_taken_1),
    .pred_taken_2  (pred_taken_2),
    .pred_target_1 (pred_target_1),
    .pred_target_2 (pred_target_2),
    .return_addr1  (return_addr1),
    .return_addr2  (return_addr2),
    .nextPC_out    (nextPC_out)
  );

  int errors = 0;
  int checks = 0;
  int bht [64];

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] JR_I = 32'h0000_0008;

  function automatic logic [31:0] mk(
    input logic [5:0] op, input int imm
  );
    logic [31:0] r;
    r = {op, 26'd0};
    r[AW-1:0] = AW'(imm);
    return r;
  endfunction

  task automatic check(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    hold = 1'b0;
    correct_en = 1'b0;
    jr = 1'b0;
    upd_en = 1'b0;
    #1;
    check("rst_valid_1", valid_1, 0);
    check("rst_valid_2", valid_2, 0);
    check("rst_pt1", pred_taken_1, 0);
    check("rst_pt2", pred_taken_2, 0);
    check("rst_next", nextPC_out, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic goto_pc(input int p);
    correct_en = 1'b1;
    correction = AW'(p);
    hold = 1'b1;
    @(negedge clk);
    correct_en = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    logic [5:0] op;
    case ($urandom_range(0, 5))
      0: op = 6'h00;
      1: op = 6'h02;
      2: op = 6'h03;
      3: op = 6'h04;
      4: op = 6'h05;
      default: op = 6'h08;
    endcase
    r = $urandom;
    r[31:26] = op;
    if (op == 6'h00) r[5:0] = 6'd0;
    return r;
  endfunction

  // Reference prediction for one slot from the instruction rules
  function automatic void ref_pred(
    input logic [31:0] ins, input int spc,
    output bit tk, output int tg
  );
    int op, imm;
    op = int'(ins[31:26]);
    imm = int'(ins[AW-1:0]);
    tk = 0;
    tg = 0;
    if (op == 2 || op == 3) begin
      tk = 1;
      tg = imm;
    end else if (op == 4 || op == 5) begin
      tk = (bht[spc % 64] >= 2);
      tg = (spc + 1 + imm) % NPC;
    end
  endfunction

  typedef struct {
    int          pc;
    logic [31:0] i1;
    logic [31:0] i2;
    logic        pt1;
    logic        v2;
    logic        pt2;
    int          nxt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    for (int i = 0; i < NPC; i++) mem[i] = NOP;

    tbl[0] = '{0, mk(6'h04, 5), NOP, 1, 0, 0, 6};
    tbl[1] = '{3, NOP, NOP, 0, 0, 0, 4};
    tbl[2] = '{1023, NOP, mk(6'h02, 9), 0, 0, 0, 0};
    tbl[3] = '{20, NOP, mk(6'h02, 40), 0, 1, 1, 40};
    tbl[4] = '{30, mk(6'h02, 100),
               mk(6'h02, 200), 1, 0, 0, 100};
    tbl[5] = '{40, mk(6'h05, 1020), NOP, 1, 0, 0, 37};
    tbl[6] = '{60, NOP, mk(6'h04, 2), 0, 1, 1, 64};
    tbl[7] = '{70, mk(6'h08, 3), NOP, 0, 1, 0, 72};

    do_reset();
    check("post_rst_pc", pc_1, 0);

    foreach (tbl[k]) begin
      mem[tbl[k].pc] = tbl[k].i1;
      mem[(tbl[k].pc + 1) % NPC] = tbl[k].i2;
      goto_pc(tbl[k].pc);
      check($sformatf("v%0d_pc", k), pc_1, tbl[k].pc);
      check($sformatf("v%0d_v1", k), valid_1, 1);
      check($sformatf("v%0d_pt1", k), pred_taken_1, tbl[k].pt1);
      check($sformatf("v%0d_v2", k), valid_2, tbl[k].v2);
      check($sformatf("v%0d_pt2", k), pred_taken_2, tbl[k].pt2);
      check($sformatf("v%0d_next", k), nextPC_out, tbl[k].nxt);
    end
    mem[1023] = NOP;
    goto_pc(1023);
    check("wrap_addr2", imem_addr_2, 0);

    // training at PC 0: beq +5, counters start weakly taken
    for (int i = 0; i < NPC; i++) mem[i] = NOP;
    mem[0] = mk(6'h04, 5);
    do_reset();
    hold = 1'b1;
    #1;
    check("init_pt1", pred_taken_1, 1);
    check("init_tgt1", pred_target_1, 6);
    check("init_v2", valid_2, 0);
    check("init_next", nextPC_out, 6);
    upd_en = 1'b1;
    upd_pc = '0;
    upd_taken = 1'b0;
    #1;
    check("same_cyc_pt1", pred_taken_1, 1);
    repeat (3) @(negedge clk);
    upd_en = 1'b0;
    #1;
    check("trained_pt1", pred_taken_1, 0);
    check("trained_v2", valid_2, 1);
    check("trained_next", nextPC_out, 2);
    upd_en = 1'b1;
    upd_taken = 1'b1;
    @(negedge clk);
    #1;
    check("sat0_then_inc", pred_taken_1, 0);
    @(negedge clk);
    upd_en = 1'b0;
    #1;
    check("inc_to_wt", pred_taken_1, 1);
    upd_en = 1'b1;
    upd_taken = 1'b0;
    @(negedge clk);
    upd_en = 1'b0;
    #1;
    check("dec_to_wnt", pred_taken_1, 0);
    do_reset();
    hold = 1'b1;
    #1;
    check("rst_restores", pred_taken_1, 1);

    // hold with correct_en, then hold alone
    correct_en = 1'b1;
    correction = AW'(100);
    #1;
    check("corr_v1", valid_1, 0);
    check("corr_v2", valid_2, 0);
    check("corr_next", nextPC_out, 100);
    @(negedge clk);
    correct_en = 1'b0;
    #1;
    check("corr_pc", pc_1, 100);
    repeat (3) @(negedge clk);
    #1;
    check("hold_pc", pc_1, 100);
    hold = 1'b0;
    @(negedge clk);
    hold = 1'b1;
    #1;
    check("adv_pc", pc_1, 102);

    // jr port alone, then jr together with correct_en
    jr = 1'b1;
    reg1Addr = AW'(7);
    #1;
    check("jr_next", nextPC_out, 7);
    check("jr_v1", valid_1, 0);
    correct_en = 1'b1;
    correction = AW'(9);
    #1;
    check("corr_over_jr", nextPC_out, 9);
    @(negedge clk);
    correct_en = 1'b0;
    jr = 1'b0;
    #1;
    check("corr_over_jr_pc", pc_1, 9);

`ifdef FETCH_RAS_EN
    do_reset();
    mem[10] = mk(6'h03, 50);
    mem[50] = JR_I;
    goto_pc(10);
    check("jal_next", nextPC_out, 50);
    hold = 1'b0;
    @(negedge clk);
    hold = 1'b1;
    #1;
    check("ras_pc", pc_1, 50);
    check("ras_pt1", pred_taken_1, 1);
    check("ras_tgt", pred_target_1, 11);
    hold = 1'b0;
    @(negedge clk);
    hold = 1'b1;
    #1;
    check("ras_ret_pc", pc_1, 11);
    goto_pc(50);
    check("ras_empty_pt1", pred_taken_1, 0);
    check("ras_empty_next", nextPC_out, 52);
`endif

    // random run against the reference model
    for (int i = 0; i < NPC; i++) mem[i] = rnd_instr();
    do_reset();
    for (int i = 0; i < 64; i++) bht[i] = 2;
    begin
      int mpc;
      mpc = 0;
      for (int c = 0; c < 400; c++) begin
        bit tk1, tk2, v1, v2, t1, t2;
        int tg1, tg2, nx, p2;
        hold = ($urandom_range(0, 3) == 0);
        correct_en = ($urandom_range(0, 15) == 0);
        correction = AW'($urandom);
        jr = ($urandom_range(0, 15) == 0);
        reg1Addr = AW'($urandom);
        upd_en = $urandom_range(0, 1);
        upd_pc = AW'($urandom);
        upd_taken = $urandom_range(0, 1);
        #1;
        p2 = (mpc + 1) % NPC;
        ref_pred(mem[mpc], mpc, tk1, tg1);
        ref_pred(mem[p2], p2, tk2, tg2);
        v1 = !correct_en && !jr;
        t1 = v1 && tk1;
        v2 = v1 && (mpc % 2 == 0) && !t1;
        t2 = v2 && tk2;
        if (correct_en)      nx = int'(correction);
        else if (jr)         nx = int'(reg1Addr);
        else if (t1)         nx = tg1;
        else if (t2)         nx = tg2;
        else if (mpc % 2)    nx = (mpc + 1) % NPC;
        else                 nx = (mpc + 2) % NPC;
        check("r_pc", pc_1, mpc);
        check("r_pc2", pc_2, p2);
        check("r_ra2", return_addr2, (mpc + 2) % NPC);
        check("r_v1", valid_1, v1);
        check("r_v2", valid_2, v2);
        check("r_pt1", pred_taken_1, t1);
        check("r_pt2", pred_taken_2, t2);
        check("r_next", nextPC_out, nx);
        if (t1) check("r_tgt1", pred_target_1, tg1);
        if (t2) check("r_tgt2", pred_target_2, tg2);
        if (upd_en) begin
          int ix;
          ix = int'(upd_pc) % 64;
          if (upd_taken && bht[ix] < 3) bht[ix]++;
          if (!upd_taken && bht[ix] > 0) bht[ix]--;
        end
        if (!hold || correct_en) mpc = nx;
        @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_predict.md
Name: fetch_predict

Overview:
- Dual-slot instruction fetch stage with a parametrised PC width and a direct-mapped bimodal branch history table (BHT) of 2-bit saturating counters.
- Each cycle it presents an aligned instruction pair and predicts jumps and branches in either slot. It redirects the PC on correction or jr, and trains the BHT from resolved branches reported by execute.
- Sits between the PC/instruction memory and the dual-issue decode stage.
- Successor to the static always-taken fetch: adds per-branch dynamic prediction, per-slot valid/prediction outputs and an optional return address stack.

Parameters:
- AW, 10, PC/instruction-address width in words.
- BHT_ENTRIES, 64, number of BHT counters; power of 2, ≥2.
- BHT_INIT, 2, reset value of every counter (2 = weakly taken).
- RAS_DEPTH, 4, return stack entries; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- hold  in  1  stall; PC keeps its value.
- correct_en  in  1  mispredict redirect from execute.
- correction  in  AW  redirect target.
- jr  in  1  jump-register redirect.
- reg1Addr  in  AW  jr target.
- upd_en  in  1  BHT training strobe.
- upd_pc  in  AW  PC of the resolved branch.
- upd_taken  in  1  resolved direction.
- imem_addr_1, imem_addr_2  out  AW  PC and PC+1 to the instruction memory; that memory is clocked on the inverted clock, so data returns in the same cycle.
- imem_data_1, imem_data_2  in  32  memory read data.
- instruction_1, instruction_2  out  32  fetched words.
- pc_1, pc_2  out  AW  slot PCs.
- valid_1, valid_2  out  1  slot carries a live instruction.
- pred_taken_1, pred_taken_2  out  1  slot predicted to redirect.
- pred_target_1, pred_target_2  out  AW  predicted target.
- return_addr1, return_addr2  out  AW  PC+1, PC+2.
- nextPC_out  out  AW  PC value selected for the next cycle.

Behaviour:
- Decode:
  - j = opcode 0x02, jal = 0x03, beq = 0x04, bne = 0x05.
  - jr = opcode 0x00 with funct 0x08.
- Targets, all arithmetic mod 2^AW:
  - Jump target = instr[AW-1:0].
  - Branch target = slot PC + 1 + instr[AW-1:0]; immediate truncated, not sign-extended.
- Prediction:
  - A branch is predicted taken when BHT[pc[IDX-1:0]][1] = 1, where IDX = log2(BHT_ENTRIES).
  - Jumps are always taken.
- Slot 1: valid_1 = rst & ~correct_en & ~jr.
- Slot 2:
  - valid_2 = valid_1 & ~PC[0] & ~pred_taken_1.
  - A not-taken slot-1 branch keeps slot 2 valid.
  - pred_taken_2 is forced 0 when valid_2 = 0.
- pc_plus = PC+1 if PC[0], else PC+2.
- nextPC priority, highest first:
  1. rst low → 0.
  2. correct_en → correction.
  3. jr → reg1Addr.
  4. Slot 1 predicted taken → pred_target_1.
  5. Slot 2 predicted taken → pred_target_2.
  6. Otherwise pc_plus.
- nextPC_out always equals that selected value.
- PC register:
  - Async clear to 0.
  - Loads nextPC on the rising edge when ~hold or correct_en; correct_en overrides hold.
- BHT training:
  - On upd_en at the rising edge, counter[upd_pc index] increments if upd_taken, else decrements.
  - Saturates at 3 and 0.
  - Training is independent of hold and correct_en.
- Same-cycle lookup and update at one index: the lookup sees the pre-update value.
- Reset:
  - All counters go to BHT_INIT and PC to 0.
  - All valid/pred_taken outputs are 0 while rst is low.
  - A reset mid-operation discards everything immediately; no partial training survives.
- Wrap-around: PC = 2^AW−1 gives pc_plus = 0 and imem_addr_2 = 0; slot 2 is invalid because PC is odd.

Optional Feature:
- Macro: FETCH_RAS_EN.
- With the macro defined:
  - A RAS_DEPTH circular return stack is present.
  - A valid jal in a slot pushes slot PC+1 when the PC advances.
  - A valid jr in a slot predicts taken to the stack top and pops on advance.
  - An empty stack gives a not-taken jr prediction; the count stays 0.
  - A push when full overwrites the oldest entry.
  - Reset empties the stack; correct_en does not repair it.
- Without the macro: fetched jr is never predicted and only the jr port redirects.

Decomposition:
- Shared package (fetch_pkg):
  - Opcode/funct constants (OP_J, OP_JAL, OP_BEQ, OP_BNE, FUNCT_JR).
  - Counter encodings (SNT=0, WNT=1, WT=2, ST=3).
- One natural sub-module: bht_bimodal, holding the counter array, read index, update port and saturation logic.
- The RAS stays inline.

Test Plan:
- Reset with BHT_INIT=2, PC=0 holding a beq at offset 5 → pred_taken_1=1, pred_target_1=6, valid_2=0; next PC=6.
- Three upd_en pulses with upd_pc=0, upd_taken=0 → counter reaches 0; refetch PC 0 gives pred_taken_1=0, valid_2=1, next PC=2.
- PC=3 (odd) → valid_2=0, next PC=4. PC=1023 with AW=10 → next PC=0.
- hold=1 with correct_en=1, correction=100 → PC=100 next cycle, valid_1=valid_2=0 during the redirect cycle. hold alone for 3 cycles → PC unchanged.
- Slot 1 not-taken branch and slot 2 j to 40 → nextPC_out=40. Simultaneous jr with reg1Addr=7 and correct_en with correction=9 → PC=9.
- FETCH_RAS_EN: jal at PC 10 to 50, then jr at 50 → predicted target 11. jr with an empty stack → pred_taken=0.
